// File: rtl/event_timestamper.sv
// ---------------------------------------------------------------------------
// event_timestamper
//
// Purpose:
//   Watches a synchronous event level and, on every rising edge, captures the
//   current value of the free-running timebase counter into a small FIFO.
//   Timestamps are presented first-word-fall-through on a valid/ready stream.
//   A sticky flag records that at least one event was lost because the FIFO
//   was full.
//
// Parameters:
//   CW       width of the timebase count and of each stored timestamp
//   LGDEPTH  log2 of FIFO depth (depth = 2**LGDEPTH), legal range 1..6
//
// Ports:
//   i_clk       system clock, shared with the timebase counter
//   i_rst_n     asynchronous active-low reset
//   i_count     current timebase value
//   i_event     event level, already synchronous to i_clk
//   i_clr       synchronous flush: empties the FIFO and clears o_overflow
//   o_data      timestamp at the FIFO head (0 while empty)
//   o_valid     o_data holds a stored timestamp
//   i_ready     consumer accepts o_data this cycle
//   o_fill      number of stored timestamps, 0..2**LGDEPTH
//   o_overflow  sticky: at least one event was dropped
// ---------------------------------------------------------------------------
module event_timestamper #(
    parameter int CW      = 16,
    parameter int LGDEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [CW-1:0]      i_count,
    input  logic               i_event,
    input  logic               i_clr,
    output logic [CW-1:0]      o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [LGDEPTH:0]   o_fill,
    output logic               o_overflow
);

    localparam int                 DEPTH     = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0]   FILL_FULL = (LGDEPTH+1)'(DEPTH);
    localparam logic [LGDEPTH:0]   FILL_ONE  = (LGDEPTH+1)'(1);
    localparam logic [LGDEPTH-1:0] PTR_ONE   = LGDEPTH'(1);

    logic [CW-1:0]      mem [DEPTH];
    logic [LGDEPTH-1:0] rd_ptr;
    logic [LGDEPTH-1:0] wr_ptr;
    logic [LGDEPTH:0]   fill;
    logic               overflow;
    logic               ev_q;

    logic push;
    logic pop;
    logic full;
    logic do_write;

    // Rising-edge detect. ev_q resets low, so a level that is already high
    // right after reset release counts as one edge.
    assign push = i_event & ~ev_q;

    // o_valid is a pure function of the registered fill count, so it (and
    // hence pop's effect on outputs) never depends combinationally on i_ready.
    assign o_valid  = (fill != '0);
    assign pop      = o_valid & i_ready;
    assign full     = (fill == FILL_FULL);

    // When full, a simultaneous pop frees the head slot, which is exactly
    // where wr_ptr points, so the new timestamp can be written there.
    assign do_write = push & (~full | pop) & ~i_clr;

    assign o_data     = o_valid ? mem[rd_ptr] : '0;
    assign o_fill     = fill;
    assign o_overflow = overflow;

    // Storage array has no reset; entries outside the fill window are
    // never observed, so stale contents are harmless.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            mem[wr_ptr] <= i_count;
        end
    end

    // Pointer, fill and flag state. Fill is tracked explicitly rather than
    // derived from the pointers so that full and empty are unambiguous.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
            ev_q     <= 1'b0;
        end else begin
            // Edge detector keeps tracking through a clear so a level held
            // high across i_clr does not produce a second push.
            ev_q <= i_event;

            if (i_clr) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fill     <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_write) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end

                if (push && !pop && !full) begin
                    fill <= fill + FILL_ONE;
                end else if (pop && !push) begin
                    fill <= fill - FILL_ONE;
                end

                if (push && full && !pop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_event_timestamper.sv
// ---------------------------------------------------------------------------
// tb_event_timestamper
//
// Directed, self-checking bench for event_timestamper (CW=16, LGDEPTH=2).
// Inputs change 1 time unit after the rising clock edge; outputs are
// examined at that same point, i.e. after the edge's updates have settled.
// ---------------------------------------------------------------------------
module tb_event_timestamper;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_count;
    logic        i_event;
    logic        i_clr;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_fill;
    logic        o_overflow;

    int n_compared;
    int n_mismatched;

    event_timestamper #(
        .CW      (16),
        .LGDEPTH (2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_count    (i_count),
        .i_event    (i_event),
        .i_clr      (i_clr),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_fill     (o_fill),
        .o_overflow (o_overflow)
    );

    // 10 time-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One-cycle event pulse captured at count c, followed by one idle cycle
    // so the next pulse is a fresh rising edge.
    task automatic pulse_event(input logic [15:0] c);
        i_count = c;
        i_event = 1'b1;
        tick();
        i_event = 1'b0;
        i_count = c + 16'h0001;
        tick();
    endtask

    // Synchronous flush used between scenarios.
    task automatic flush();
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_event = 1'b0;
        i_ready = 1'b0;
        i_clr   = 1'b0;
        i_count = 16'h0000;
        tick();
        tick();
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_count = 16'h0008 + 16'(k);
            tick();
        end
        n_compared++;
        if (o_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_valid: got %b expected 0", o_valid);
        end
        n_compared++;
        if (o_fill !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_fill: got %0d expected 0", o_fill);
        end
        n_compared++;
        if (o_overflow !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_overflow: got %b expected 0", o_overflow);
        end
        n_compared++;
        if (o_data !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data: got %h expected 0000", o_data);
        end

        // First event: visible the very next cycle.
        i_count = 16'h0010;
        i_event = 1'b1;
        tick();
        i_event = 1'b0;
        i_count = 16'h0011;
        n_compared++;
        if (o_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL first_valid: got %b expected 1", o_valid);
        end
        n_compared++;
        if (o_data !== 16'h0010) begin
            n_mismatched++;
            $display("[TB] FAIL first_data: got %h expected 0010", o_data);
        end
        n_compared++;
        if (o_fill !== 3'd1) begin
            n_mismatched++;
            $display("[TB] FAIL first_fill: got %0d expected 1", o_fill);
        end
        tick();
        flush();
    endtask

    task automatic test_level_hold();
        i_event = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_count = 16'h0020 + 16'(k);
            tick();
        end
        i_event = 1'b0;
        tick();
        n_compared++;
        if (o_fill !== 3'd1) begin
            n_mismatched++;
            $display("[TB] FAIL hold_fill: got %0d expected 1", o_fill);
        end
        n_compared++;
        if (o_data !== 16'h0020) begin
            n_mismatched++;
            $display("[TB] FAIL hold_data: got %h expected 0020", o_data);
        end
        pulse_event(16'h0040);
        n_compared++;
        if (o_fill !== 3'd2) begin
            n_mismatched++;
            $display("[TB] FAIL second_edge_fill: got %0d expected 2", o_fill);
        end
        i_ready = 1'b1;
        tick();
        n_compared++;
        if (o_data !== 16'h0040) begin
            n_mismatched++;
            $display("[TB] FAIL hold_second_data: got %h expected 0040", o_data);
        end
        tick();
        i_ready = 1'b0;
        n_compared++;
        if (o_fill !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL hold_drain_fill: got %0d expected 0", o_fill);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_data [4];
        exp_data[0] = 16'h0100;
        exp_data[1] = 16'h0104;
        exp_data[2] = 16'h0108;
        exp_data[3] = 16'h010C;
        for (int k = 0; k < 4; k++) begin
            pulse_event(exp_data[k]);
        end
        pulse_event(16'h0110);
        n_compared++;
        if (o_fill !== 3'd4) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_fill: got %0d expected 4", o_fill);
        end
        n_compared++;
        if (o_overflow !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_flag: got %b expected 1", o_overflow);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_compared++;
            if (o_valid !== 1'b1 || o_data !== exp_data[k]) begin
                n_mismatched++;
                $display("[TB] FAIL ovf_read%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, o_valid, o_data, exp_data[k]);
            end
            tick();
        end
        i_ready = 1'b0;
        n_compared++;
        if (o_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_empty_valid: got %b expected 0", o_valid);
        end
        n_compared++;
        if (o_overflow !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_sticky: got %b expected 1", o_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_data [4];
        flush();
        n_compared++;
        if (o_overflow !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL clr_overflow: got %b expected 0", o_overflow);
        end
        for (int k = 0; k < 4; k++) begin
            pulse_event(16'h0180 + 16'(4 * k));
        end
        i_count = 16'h0200;
        i_event = 1'b1;
        i_ready = 1'b1;
        tick();
        i_event = 1'b0;
        i_ready = 1'b0;
        n_compared++;
        if (o_fill !== 3'd4) begin
            n_mismatched++;
            $display("[TB] FAIL fullpp_fill: got %0d expected 4", o_fill);
        end
        n_compared++;
        if (o_overflow !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fullpp_overflow: got %b expected 0", o_overflow);
        end
        exp_data[0] = 16'h0184;
        exp_data[1] = 16'h0188;
        exp_data[2] = 16'h018C;
        exp_data[3] = 16'h0200;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_compared++;
            if (o_data !== exp_data[k]) begin
                n_mismatched++;
                $display("[TB] FAIL fullpp_read%0d: got %h expected %h", k, o_data, exp_data[k]);
            end
            tick();
        end
        i_ready = 1'b0;
    endtask

    task automatic test_empty_ready();
        i_ready = 1'b1;
        i_count = 16'h0300;
        i_event = 1'b1;
        tick();
        i_event = 1'b0;
        n_compared++;
        if (o_valid !== 1'b1 || o_data !== 16'h0300 || o_fill !== 3'd1) begin
            n_mismatched++;
            $display("[TB] FAIL empty_ready_push: got valid=%b data=%h fill=%0d expected valid=1 data=0300 fill=1",
                     o_valid, o_data, o_fill);
        end
        tick();
        i_ready = 1'b0;
        n_compared++;
        if (o_fill !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL empty_ready_pop: got fill=%0d expected 0", o_fill);
        end
    endtask

    task automatic test_wrap();
        pulse_event(16'hFFFF);
        pulse_event(16'h0001);
        i_ready = 1'b1;
        n_compared++;
        if (o_data !== 16'hFFFF) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_first: got %h expected ffff", o_data);
        end
        tick();
        n_compared++;
        if (o_data !== 16'h0001) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_second: got %h expected 0001", o_data);
        end
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_clear();
        for (int k = 0; k < 5; k++) begin
            pulse_event(16'h0400 + 16'(k));
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        n_compared++;
        if (o_fill !== 3'd3 || o_overflow !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL clr_setup: got fill=%0d ovf=%b expected fill=3 ovf=1", o_fill, o_overflow);
        end
        i_clr   = 1'b1;
        i_event = 1'b1;
        i_count = 16'h0500;
        tick();
        i_clr = 1'b0;
        n_compared++;
        if (o_fill !== 3'd0 || o_valid !== 1'b0 || o_overflow !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL clr_result: got fill=%0d valid=%b ovf=%b expected 0 0 0",
                     o_fill, o_valid, o_overflow);
        end
        // Level still high after the clear must not re-trigger.
        tick();
        i_event = 1'b0;
        tick();
        n_compared++;
        if (o_fill !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL clr_no_retrigger: got fill=%0d expected 0", o_fill);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            pulse_event(16'h0600 + 16'(k));
        end
        i_count = 16'h0700;
        i_event = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        n_compared++;
        if (o_valid !== 1'b0 || o_fill !== 3'd0 || o_overflow !== 1'b0 || o_data !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: got valid=%b fill=%0d ovf=%b data=%h expected all 0",
                     o_valid, o_fill, o_overflow, o_data);
        end
        i_event = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        n_compared++;
        if (o_fill !== 3'd0 || o_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_empty: got fill=%0d valid=%b expected 0 0", o_fill, o_valid);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_level_hold();
        test_overflow();
        test_full_push_pop();
        test_empty_ready();
        test_wrap();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/event_timestamper.md
Name: event_timestamper

Overview:
- Downstream consumer of the free-running timebase counter.
- On each rising edge of an event input, latches the current count value as a timestamp into a small FIFO.
- Presents timestamps on a valid/ready stream for software-visible or logging logic.
- Flags lost events when the FIFO is full.

Parameters:
- CW, 16, width of timebase count and of each stored timestamp.
- LGDEPTH, 2, log2 of FIFO depth; depth = 2**LGDEPTH; legal range 1..6.

Ports:
- i_clk  input  1  system clock; the timebase counter runs on the same clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_count  input  CW  current timebase value from the upstream counter.
- i_event  input  1  event level, already synchronous to i_clk.
- i_clr  input  1  synchronous flush: empties FIFO, clears o_overflow.
- o_data  output  CW  timestamp at FIFO head.
- o_valid  output  1  o_data holds a stored timestamp.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_fill  output  LGDEPTH+1  number of stored timestamps, 0..2**LGDEPTH.
- o_overflow  output  1  sticky; at least one event was dropped.

Behaviour:
- Interface: one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
- Reset (i_rst_n=0, asynchronous assert):
  - Read pointer, write pointer and o_fill = 0; o_valid = 0; o_overflow = 0.
  - Edge-detect register = 0.
  - o_data = 0 while empty.
  - Memory contents are don't-care.
- Edge detect:
  - Internal ev_q <= i_event every cycle.
  - push = i_event & ~ev_q.
  - Because ev_q resets to 0, an i_event already high on the first cycle after reset release counts as one edge.
  - A level held high yields exactly one push.
- Capture timing: on a push in cycle t, the i_count value sampled in cycle t is written at the end of cycle t.
- Stored value is raw i_count: no offset and no wrap correction. Counter wrap from 2**CW-1 to 0 is stored as-is.
- Output (first-word-fall-through):
  - o_valid = (o_fill != 0); o_data = mem[rd_ptr] whenever o_valid = 1.
  - pop = o_valid & i_ready.
  - o_data/o_valid must not depend combinationally on i_ready.
- Latency: a push in cycle t into an empty FIFO gives o_valid=1 with that timestamp in cycle t+1.
- Fill state (EMPTY: fill=0; PART: 0<fill<depth; FULL: fill=depth):
  - push & ~pop & ~FULL: write, wr_ptr+1, fill+1.
  - pop & ~push: rd_ptr+1, fill-1.
  - push & pop, any non-empty state including FULL: write and read both occur, fill unchanged, no overflow.
  - push & FULL & ~pop: event dropped, fill unchanged, o_overflow <= 1.
  - push & EMPTY & i_ready: no pop, because o_valid=0; the push is stored.
- Pointers are LGDEPTH bits and wrap modulo depth. o_fill is tracked explicitly, not derived from pointers.
- o_overflow is sticky: cleared only by reset or i_clr.
- i_clr = 1:
  - Next cycle: fill=0, pointers=0, o_overflow=0.
  - A push and/or pop in the same cycle is discarded; i_clr dominates.
  - ev_q is still updated, so a level high across the clear does not re-trigger.
- Reset asserted mid-operation clears all state immediately. No partial write may survive.

Test Plan:
1. Reset release with i_event=0, i_ready=0, i_count ramping: o_valid=0, o_fill=0, o_overflow=0. Pulse i_event in a cycle where i_count=0x0010 -> next cycle o_valid=1, o_data=0x0010, o_fill=1.
2. i_event held high for 10 cycles -> exactly one entry. A second rising edge after it drops -> o_fill=2.
3. i_ready=0, five single-cycle events at counts 0x0100, 0x0104, 0x0108, 0x010C, 0x0110 -> o_fill=4, o_overflow=1. Then i_ready=1 -> reads 0x0100, 0x0104, 0x0108, 0x010C and o_valid=0; o_overflow stays 1.
4. FIFO full, i_ready=1 in the same cycle as an event at count 0x0200 -> oldest entry popped, 0x0200 stored, o_fill stays 4, o_overflow stays 0.
5. Counter wrap: events at i_count=0xFFFF and then 0x0001 -> read back 0xFFFF then 0x0001 unchanged.
6. Three entries stored, o_overflow=1:
   - i_clr together with an event -> next cycle o_fill=0, o_valid=0, o_overflow=0, event not stored.
   - Separately, assert i_rst_n=0 mid-burst -> all outputs 0 immediately, without waiting for a clock edge.
